// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU with 1-cycle logic/arith/compare ops and an iterative
// unsigned multiply/divide unit (one bit per cycle) feeding HI/LO.
//
//  state | meaning
//  IDLE  | ready for any op; single-cycle ops complete here
//  BUSY  | one MULTU/DIVU iteration per edge, ready low
//  DONE  | mul/div result presented with done; a new op may be accepted
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             ready_q, done_q, zero_q, is_div_q;
    logic [WIDTH-1:0] out_q, hi_q, lo_q;
    logic [WIDTH-1:0] wh_q, wl_q, opnd_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             is_muldiv;

    always_comb begin
        alu_res = '0;
        case (aluOp)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign is_muldiv = (aluOp == OP_MULTU) || (aluOp == OP_DIVU);

    // Multiply: wh:wl holds partial product with the multiplier shifting out of wl.
    // Divide: wh is the running remainder, wl shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {wh_q, wl_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        if (is_div_q) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {wl_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], wl_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            out_q    <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    wh_q  <= step_hi;
                    wl_q  <= step_lo;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        hi_q    <= step_hi;
                        lo_q    <= step_lo;
                        out_q   <= step_lo;
                        zero_q  <= (step_lo == '0);
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        if (is_muldiv) begin
                            is_div_q <= (aluOp == OP_DIVU);
                            opnd_q   <= (aluOp == OP_DIVU) ? b : a;
                            wl_q     <= (aluOp == OP_DIVU) ? a : b;
                            wh_q     <= '0;
                            cnt_q    <= '0;
                            ready_q  <= 1'b0;
                            state_q  <= S_BUSY;
                        end else begin
                            out_q  <= alu_res;
                            zero_q <= (alu_res == '0);
                            done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign out   = out_q;
    assign zero  = zero_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
